// File: rtl/instr_cache.sv
// rtl/instr_cache.sv - direct-mapped read-only instruction cache with word-serial line refill
//
// Purpose: 0-cycle hit path from PCF to InstrF; on a miss, stalls fetch and
// refills the whole line from instruction memory, one 32-bit beat per MemValid.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous active-low reset
//   PCF          fetch PC (bits [1:0] ignored)
//   StallF       pipeline fetch stall (feeds the hit counter only)
//   InvalidateF  single-cycle pulse, invalidates every line
//   InstrF       instruction for PCF (NOP while stalled)
//   CacheStallF  high while InstrF is not valid
//   MemReq       refill request, held for the whole burst
//   MemAddr      line-aligned refill address (0 when idle)
//   MemValid     one refill beat this cycle
//   MemData      refill beat data
//   HitCount     hit counter   (only with ICACHE_PERF_CNT_EN)
//   MissCount    miss counter  (only with ICACHE_PERF_CNT_EN)
//
// Optional feature macro: ICACHE_PERF_CNT_EN

module instr_cache #(
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  input  logic        StallF,
  input  logic        InvalidateF,
  output logic [31:0] InstrF,
  output logic        CacheStallF,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemValid,
  input  logic [31:0] MemData
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] HitCount,
  output logic [31:0] MissCount
`endif
);

  localparam int O  = $clog2(WORDS_PER_LINE);
  localparam int I  = $clog2(NUM_LINES);
  localparam int TW = 30 - O - I;
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_REFILL = 1'b1;

  logic [O-1:0]  offset;
  logic [I-1:0]  index;
  logic [TW-1:0] tag;

  assign offset = PCF[O+1:2];
  assign index  = PCF[O+I+1:O+2];
  assign tag    = PCF[31:O+I+2];

  logic [0:0]           state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TW-1:0]        rtag_q, rtag_d;
  logic [I-1:0]         ridx_q, ridx_d;
  logic [O-1:0]         beat_q, beat_d;
  logic                 pend_q, pend_d;

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  logic [TW-1:0] tag_q  [NUM_LINES];
  logic [31:0]   data_q [NUM_LINES][WORDS_PER_LINE];

  logic hit;
  logic beat_wr;
  logic last_beat;

  assign hit       = (state_q == S_IDLE) && valid_q[index] && (tag_q[index] == tag);
  assign beat_wr   = (state_q == S_REFILL) && MemValid;
  assign last_beat = beat_wr && (beat_q == {O{1'b1}});

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    rtag_d  = rtag_q;
    ridx_d  = ridx_q;
    beat_d  = beat_q;
    pend_d  = pend_q;

    case (state_q)
      S_IDLE: begin
        if (!hit) begin
          state_d = S_REFILL;
          rtag_d  = tag;
          ridx_d  = index;
          beat_d  = '0;
        end
      end
      S_REFILL: begin
        if (beat_wr) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            state_d = S_IDLE;
            pend_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The lookup above used the old valid bits; the flush lands at the edge.
    // A flush during a burst (other than on its last beat) is remembered so
    // the line being filled comes out invalid.
    if (InvalidateF) begin
      valid_d = '0;
      if ((state_q == S_REFILL) && !last_beat) pend_d = 1'b1;
    end

    if (last_beat && !pend_q && !InvalidateF) valid_d[ridx_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      rtag_q  <= '0;
      ridx_q  <= '0;
      beat_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      rtag_q  <= rtag_d;
      ridx_q  <= ridx_d;
      beat_q  <= beat_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_wr)   data_q[ridx_q][beat_q] <= MemData;
    if (last_beat) tag_q[ridx_q]          <= rtag_q;
  end

  assign InstrF      = hit ? data_q[index][offset] : NOP;
  assign CacheStallF = !hit;
  assign MemReq      = (state_q == S_REFILL);
  assign MemAddr     = MemReq ? {rtag_q, ridx_q, {(O+2){1'b0}}} : 32'h0;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit && !StallF) hit_cnt_q <= hit_cnt_q + 32'd1;
      if ((state_q == S_IDLE) && !hit) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign HitCount  = hit_cnt_q;
  assign MissCount = miss_cnt_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^PCF[1:0];
`else
  logic unused_inputs;
  assign unused_inputs = ^{PCF[1:0], StallF};
`endif

endmodule
